alu_operand_seq: RTL

- Sequential front-end that sits directly upstream of the 4-bit combinational ALU and drives its a, b and ctrl inputs.
- Operator keys in operand A, operand B and the opcode from board switches, one confirm-button press per field.
- Block fires one execute cycle, latches the ALU's res/car/of into holding registers for the display stage, and counts completed operations.

---
 rtl/alu_operand_seq_if.sv | 23 ++
 rtl/alu_operand_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_operand_seq_if.sv
// Bus between the operand sequencer and the combinational ALU it drives.
// The sequencer is the master: it presents operands/opcode and reads back result and flags.
interface alu_operand_seq_if #(
    parameter int DW  = 4,
    parameter int OPW = 3
);
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_ctrl;
    logic [DW-1:0]  alu_res;
    logic           alu_car;
    logic           alu_of;

    modport master (
        output alu_a, alu_b, alu_ctrl,
        input  alu_res, alu_car, alu_of
    );

    modport slave (
        input  alu_a, alu_b, alu_ctrl,
        output alu_res, alu_car, alu_of
    );
endinterface

// File: rtl/alu_operand_seq.sv
// Switch/button front-end for a 4-bit ALU: captures A, B and opcode on three button
// presses, runs one execute cycle, latches result/flags and counts completed operations.
module alu_operand_seq #(
    parameter int DW   = 4,
    parameter int OPW  = 3,
    parameter int CNTW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    i_sw,
    input  logic [OPW-1:0]   i_op_sw,
    input  logic             i_btn,
    input  logic             i_btn_clr,
    alu_operand_seq_if.master alu_bus,
    output logic [DW-1:0]    o_res_q,
    output logic             o_car_q,
    output logic             o_of_q,
    output logic [2:0]       o_state_code,
    output logic             o_done,
    output logic [CNTW-1:0]  o_op_cnt
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Bit 0 is the confirm button, bit 1 the clear button.
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {i_btn_clr, i_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn_sync
            logic r_sync1;
            logic r_sync2;
            logic r_hist;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_hist  <= 1'b0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    r_hist  <= r_sync2;
                end
            end

            assign w_press[gi] = r_sync2 & ~r_hist;
        end
    endgenerate

    logic            w_btn_press;
    logic            w_clr_press;

    assign w_btn_press = w_press[0];
    assign w_clr_press = w_press[1];

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   w_a_next;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   w_b_next;
    logic [OPW-1:0]  r_ctrl;
    logic [OPW-1:0]  w_ctrl_next;
    logic [DW-1:0]   r_res;
    logic [DW-1:0]   w_res_next;
    logic            r_car;
    logic            w_car_next;
    logic            r_of;
    logic            w_of_next;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_ctrl  <= '0;
            r_res   <= '0;
            r_car   <= 1'b0;
            r_of    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_ctrl  <= w_ctrl_next;
            r_res   <= w_res_next;
            r_car   <= w_car_next;
            r_of    <= w_of_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_ctrl_next  = r_ctrl;
        w_res_next   = r_res;
        w_car_next   = r_car;
        w_of_next    = r_of;
        w_cnt_next   = r_cnt;

        // Clear wins over any press and over the execute-cycle latch.
        if (w_clr_press) begin
            w_state_next = S_A;
            w_a_next     = '0;
            w_b_next     = '0;
            w_ctrl_next  = '0;
            w_res_next   = '0;
            w_car_next   = 1'b0;
            w_of_next    = 1'b0;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_btn_press) begin
                        w_a_next     = i_sw;
                        w_state_next = S_B;
                    end
                end
                S_B: begin
                    if (w_btn_press) begin
                        w_b_next     = i_sw;
                        w_state_next = S_OP;
                    end
                end
                S_OP: begin
                    if (w_btn_press) begin
                        w_ctrl_next  = i_op_sw;
                        w_state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_res_next   = alu_bus.alu_res;
                    w_car_next   = alu_bus.alu_car;
                    w_of_next    = alu_bus.alu_of;
                    w_cnt_next   = r_cnt + CNTW'(1);
                    w_state_next = S_SHOW;
                end
                S_SHOW: begin
                    if (w_btn_press) begin
                        w_state_next = S_A;
                    end
                end
                default: begin
                    w_state_next = S_A;
                end
            endcase
        end
    end

    assign alu_bus.alu_a    = r_a;
    assign alu_bus.alu_b    = r_b;
    assign alu_bus.alu_ctrl = r_ctrl;

    assign o_res_q      = r_res;
    assign o_car_q      = r_car;
    assign o_of_q       = r_of;
    assign o_op_cnt     = r_cnt;
    assign o_state_code = r_state;
    assign o_done       = (r_state == S_SHOW);

endmodule
